regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x16-bit MIPS16 register file among NUM_REQ writeback requesters, e.g. ALU writeback and load writeback.
- Arbitrates requesters round-robin and drives one registered write per cycle into the register file.
- Includes a per-register busy scoreboard: decode sets a bit when it issues a producer, and the write that completes that producer clears it. Hazard logic reads the scoreboard.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, number of architectural registers (2**ADDR_W).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  writeback request valid, one bit per requester.
- req_ready  output  NUM_REQ  grant/accept, one bit per requester.
- req_dest  input  NUM_REQ*ADDR_W  destination register; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  write data; requester i occupies slice [i*DATA_W +: DATA_W].
- claim_valid  input  1  decode issued an instruction that will write claim_dest.
- claim_dest  input  ADDR_W  register being claimed.
- reg_write_en  output  1  to register file write enable.
- reg_write_dest  output  ADDR_W  to register file write address.
- reg_write_data  output  DATA_W  to register file write data.
- busy  output  NUM_REGS  scoreboard; bit r=1 means a write to register r is outstanding.
- err_unclaimed  output  1  sticky flag: a write was accepted to a register whose busy bit was 0.

Behaviour:
- Reset is asynchronous, active-high; clock is clock. While reset is asserted:
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0.
  - busy=0, err_unclaimed=0, round-robin pointer=0.
  - An in-flight output write is dropped. Releasing reset does not replay it.
- Arbitration is combinational within the cycle:
  - Search starts at pointer ptr and proceeds ptr, ptr+1, ... mod NUM_REQ.
  - The first requester with req_valid=1 is granted.
  - req_ready is one-hot on that requester, or all-zero if no requester is valid.
  - A transfer completes when req_valid[i] & req_ready[i] at the rising edge.
- Pointer update: after a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Output stage (latency 1 cycle from accept to reg_write_en):
  - On an accept, reg_write_dest and reg_write_data load the granted slices.
  - reg_write_en loads 1 unless dest==0.
  - With no accept, reg_write_en <= 0, and dest/data hold their last values.
  - Throughput is 1 write per cycle. Requesters must hold dest/data stable while valid and not ready.
- Writes to register 0:
  - Writeback request to dest 0: the handshake still completes, reg_write_en stays 0, and the scoreboard and error flag are unaffected.
  - Claim of register 0 is ignored; busy[0] is always 0.
- Scoreboard, applied at the rising edge:
  - Clear busy[d] when a request to d≠0 is accepted.
  - Set busy[claim_dest] when claim_valid=1 and claim_dest≠0.
  - Same register cleared and claimed in the same cycle: set wins, because the new producer is outstanding.
  - Claim of an already-busy register: the bit stays 1. There is no count, so a WAW pair is resolved by decode stalling.
- err_unclaimed: set when an accept to d≠0 occurs while busy[d]=0. It clears only on reset.
- No combinational path from req_* to reg_write_*. Only req_ready depends combinationally on req_valid and ptr.

Optional Feature:
- REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and the pointer register is removed. All other behaviour is unchanged.
- REGFILE_ARB_FIXED_PRIO_EN undefined: round-robin as above.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_ADDR_W=4, REG_DATA_W=16, NUM_ARCH_REGS=16, ZERO_REG=0;
  - typedef reg_addr_t [3:0] and reg_data_t [15:0].
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant with a pointer input. It contains the fixed-priority branch under the macro.
- The scoreboard and output stage stay in the top level.

Test Plan:
- Reset mid-transfer: accept dest 5 / 0x1234, then assert reset before the next edge → reg_write_en=0, busy=0, ptr=0. No write of 0x1234 appears after reset release.
- Round-robin: hold both valid for 4 cycles, dest 3/4, data 0xAAAA/0x5555 → grants 0,1,0,1. reg_write_en=1 each cycle from cycle 1, with dest sequence 3,4,3,4.
- Zero register: requester 1 writes dest 0 / 0xFFFF → req_ready[1]=1, reg_write_en stays 0, busy unchanged, err_unclaimed=0.
- Scoreboard: claim 7, then writeback to 7 two cycles later → busy[7]=1 for exactly 2 cycles after the claim edge, then 0. Claim 7 on the same cycle as the writeback to 7 → busy[7] remains 1.
- Unclaimed write: writeback to 9 with busy[9]=0 → err_unclaimed=1 and it remains set until reset.
- With REGFILE_ARB_FIXED_PRIO_EN: both requesters valid for 3 cycles → requester 0 is granted every cycle and req_ready[1]=0 throughout.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file constants and types for the MIPS16 register file
package regfile_pkg;

    localparam int REG_ADDR_W    = 4;
    localparam int REG_DATA_W    = 16;
    localparam int NUM_ARCH_REGS = 16;
    localparam int ZERO_REG      = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - combinational round-robin grant from a pointer;
// REGFILE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        idx         = 0;
        sel         = '0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        // Scan downward so the lowest requesting index is the last one written
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sel = PTR_W'(i);
            if (req_i[sel]) begin
                gnt_idx_o   = sel;
                gnt_valid_o = 1'b1;
            end
        end
`else
        // Scan offsets downward so the requester closest to ptr_i wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (req_i[sel]) begin
                gnt_idx_o   = sel;
                gnt_valid_o = 1'b1;
            end
        end
`endif
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - arbitrated register file write port with busy scoreboard;
// REGFILE_ARB_FIXED_PRIO_EN selects fixed priority and removes the round-robin pointer
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = NUM_ARCH_REGS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        claim_valid,
    input  logic [ADDR_W-1:0]           claim_dest,
    output logic                        reg_write_en,
    output logic [ADDR_W-1:0]           reg_write_dest,
    output logic [DATA_W-1:0]           reg_write_data,
    output logic [NUM_REGS-1:0]         busy,
    output logic                        err_unclaimed
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0]   dest_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    gnt_idx;
    logic                accept;
    logic [ADDR_W-1:0]   sel_dest;
    logic [DATA_W-1:0]   sel_data;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dest_arr[i] = req_dest[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (req_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (accept)
    );

    assign sel_dest = dest_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        err_d     = err_q;
        if (accept) begin
            wr_dest_d = sel_dest;
            wr_data_d = sel_data;
            if (sel_dest != ZERO_ADDR) begin
                wr_en_d           = 1'b1;
                err_d             = err_q | ~busy_q[sel_dest];
                busy_d[sel_dest]  = 1'b0;
            end
        end
        // Claim is applied after the clear so a new producer stays outstanding
        if (claim_valid && (claim_dest != ZERO_ADDR)) begin
            busy_d[claim_dest] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign busy           = busy_q;
    assign err_unclaimed  = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_dest;
    logic [31:0] req_data;
    logic        claim_valid;
    logic [3:0]  claim_dest;
    logic        reg_write_en;
    logic [3:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [15:0] busy;
    logic        err_unclaimed;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q [$];

    regfile_write_arbiter #(
        .NUM_REQ  (2),
        .DATA_W   (16),
        .ADDR_W   (4),
        .NUM_REGS (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .claim_valid    (claim_valid),
        .claim_dest     (claim_dest),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .busy           (busy),
        .err_unclaimed  (err_unclaimed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] d0, input logic [15:0] x0,
                         input logic [3:0] d1, input logic [15:0] x1);
        req_valid = v;
        req_dest  = {d1, d0};
        req_data  = {x1, x0};
    endtask

    // Monitor: every presented register file write must match the next queued expectation
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && reg_write_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%h/%h required=none",
                             reg_write_dest, reg_write_data);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    if ({reg_write_dest, reg_write_data} !== e) begin
                        errors++;
                        $display("FAIL write actual=%h/%h required=%h/%h",
                                 reg_write_dest, reg_write_data, e[19:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_rdy [4];
        logic [3:0] exp_dst [4];
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_dst = '{4'd3, 4'd3, 4'd3, 4'd3};
`else
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_dst = '{4'd3, 4'd4, 4'd3, 4'd4};
`endif
        reset       = 1'b1;
        claim_valid = 1'b0;
        claim_dest  = 4'd0;
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        #2;
        chk("reset_wr_en", {31'b0, reg_write_en}, 32'd0);
        chk("reset_busy", {16'b0, busy}, 32'd0);
        chk("reset_err", {31'b0, err_unclaimed}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Accept a write, then drop it with an asynchronous reset before it lands
        drive(2'b01, 4'd5, 16'h1234, 4'd0, 16'h0);
        #1;
        chk("mid_ready", {30'b0, req_ready}, 32'd1);
        tick();
        chk("mid_out", {reg_write_en, 11'b0, reg_write_dest, reg_write_data}, {1'b1, 11'b0, 4'd5, 16'h1234});
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        reset = 1'b1;
        #1;
        chk("mid_reset_out", {reg_write_en, 11'b0, reg_write_dest, reg_write_data}, 32'd0);
        chk("mid_reset_busy", {16'b0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Both requesters valid: pointer must restart at 0 after reset
        drive(2'b11, 4'd3, 16'hAAAA, 4'd4, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_ready%0d", i), {30'b0, req_ready}, {30'b0, exp_rdy[i]});
            exp_q.push_back({exp_dst[i], (exp_dst[i] == 4'd3) ? 16'hAAAA : 16'h5555});
            tick();
        end
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Write to register 0 alongside a claim of register 0
        drive(2'b10, 4'd0, 16'h0, 4'd0, 16'hFFFF);
        claim_valid = 1'b1;
        claim_dest  = 4'd0;
        #1;
        chk("zero_ready", {30'b0, req_ready}, 32'd2);
        tick();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        claim_valid = 1'b0;
        chk("zero_wr_en", {31'b0, reg_write_en}, 32'd0);
        chk("zero_loaded", {12'b0, reg_write_dest, reg_write_data}, {12'b0, 4'd0, 16'hFFFF});
        chk("zero_busy", {16'b0, busy}, 32'd0);
        chk("zero_err", {31'b0, err_unclaimed}, 32'd0);

        // Claim 7, write back to 7 two cycles later
        claim_valid = 1'b1;
        claim_dest  = 4'd7;
        tick();
        claim_valid = 1'b0;
        chk("sb_busy_c1", {16'b0, busy}, 32'h0080);
        tick();
        chk("sb_busy_c2", {16'b0, busy}, 32'h0080);
        drive(2'b01, 4'd7, 16'h0777, 4'd0, 16'h0);
        exp_q.push_back({4'd7, 16'h0777});
        tick();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("sb_busy_clr", {16'b0, busy}, 32'h0000);
        chk("sb_err", {31'b0, err_unclaimed}, 32'd0);

        // Claim and writeback to the same register in one cycle: set wins
        claim_valid = 1'b1;
        tick();
        drive(2'b01, 4'd7, 16'h1777, 4'd0, 16'h0);
        exp_q.push_back({4'd7, 16'h1777});
        tick();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        claim_valid = 1'b0;
        chk("sb_set_wins", {16'b0, busy}, 32'h0080);
        chk("sb_err2", {31'b0, err_unclaimed}, 32'd0);
        drive(2'b01, 4'd7, 16'h2777, 4'd0, 16'h0);
        exp_q.push_back({4'd7, 16'h2777});
        tick();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("sb_busy_final", {16'b0, busy}, 32'h0000);
        chk("sb_err3", {31'b0, err_unclaimed}, 32'd0);

        // Unclaimed write to 9 sets the sticky error
        drive(2'b01, 4'd9, 16'h0999, 4'd0, 16'h0);
        exp_q.push_back({4'd9, 16'h0999});
        tick();
        drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("err_set", {31'b0, err_unclaimed}, 32'd1);
        tick();
        tick();
        chk("err_sticky", {31'b0, err_unclaimed}, 32'd1);
        reset = 1'b1;
        #1;
        chk("err_reset", {31'b0, err_unclaimed}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
